// File: rtl/ad9516_spi_reader_if.sv
// Request/response bundle between a register-verification client and the AD9516 read engine.
interface ad9516_spi_reader_if;
    logic        rd_req;
    logic        rd_ready;
    logic [12:0] rd_addr;
    logic [7:0]  rd_exp;
    logic [7:0]  rd_mask;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_match;
    logic        busy;

    modport master (
        output rd_req, rd_addr, rd_exp, rd_mask,
        input  rd_ready, rd_valid, rd_data, rd_match, busy
    );

    modport slave (
        input  rd_req, rd_addr, rd_exp, rd_mask,
        output rd_ready, rd_valid, rd_data, rd_match, busy
    );
endinterface

// File: rtl/ad9516_spi_reader.sv
// Single-byte AD9516 register read over 4-wire SPI (instruction on SDIO, data from SDO),
// returning the captured byte plus a masked compare against an expected value.
module ad9516_spi_reader #(
    parameter int CLK_DIV  = 5,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 4
) (
    input  logic               sys_clk_i,
    input  logic               rst_n,
    ad9516_spi_reader_if.slave rd,
    output logic               spi_sclk,
    output logic               spi_cs_n,
    output logic               spi_sdio,
    input  logic               spi_sdo
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int HW = $clog2(CLK_DIV);
    localparam int CW = 16;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] half_cnt;
    logic          phase;
    logic [4:0]    bit_cnt;
    logic [15:0]   tx_sr;
    logic [7:0]    rx_sr;
    logic [7:0]    exp_q;
    logic [7:0]    mask_q;

    logic accept, half_end, sclk_rise, bit_end, setup_done;

    function automatic logic masked_match(input logic [7:0] d, input logic [7:0] e,
                                          input logic [7:0] m);
        return ((d ^ e) & m) == 8'h00;
    endfunction

    always_comb begin
        accept     = rd.rd_req && rd.rd_ready && (state == S_IDLE);
        half_end   = (half_cnt == HW'(CLK_DIV - 1));
        sclk_rise  = (state == S_SHIFT) && half_end && !phase;
        bit_end    = (state == S_SHIFT) && half_end && phase;
        setup_done = (state == S_SETUP) && (cnt == CW'(CS_SETUP - 1));
    end

    // Instruction shifter drains to zero after 16 bits, so SDIO idles low through the data phase.
    always_ff @(posedge sys_clk_i) begin
        if (accept) begin
            tx_sr  <= {1'b1, 2'b00, rd.rd_addr};
            exp_q  <= rd.rd_exp;
            mask_q <= rd.rd_mask;
        end else if (setup_done || (bit_end && bit_cnt != 5'd23)) begin
            tx_sr <= {tx_sr[14:0], 1'b0};
        end
        if (sclk_rise && bit_cnt >= 5'd16)
            rx_sr <= {rx_sr[6:0], spi_sdo};
    end

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            half_cnt    <= '0;
            phase       <= 1'b0;
            bit_cnt     <= '0;
            spi_cs_n    <= 1'b1;
            spi_sclk    <= 1'b0;
            spi_sdio    <= 1'b0;
            rd.busy     <= 1'b0;
            rd.rd_ready <= 1'b0;
            rd.rd_valid <= 1'b0;
            rd.rd_data  <= '0;
            rd.rd_match <= 1'b0;
        end else begin
            rd.rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    rd.rd_ready <= 1'b1;
                    if (accept) begin
                        rd.rd_ready <= 1'b0;
                        rd.busy     <= 1'b1;
                        spi_cs_n    <= 1'b0;
                        cnt         <= '0;
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (setup_done) begin
                        spi_sdio <= tx_sr[15];
                        half_cnt <= '0;
                        phase    <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!half_end) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else begin
                        half_cnt <= '0;
                        phase    <= !phase;
                        spi_sclk <= !phase;
                        if (phase) begin
                            if (bit_cnt == 5'd23) begin
                                spi_sdio <= 1'b0;
                                cnt      <= '0;
                                state    <= S_HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                spi_sdio <= tx_sr[15];
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (cnt == CW'(CS_HOLD - 1)) begin
                        spi_cs_n    <= 1'b1;
                        rd.rd_valid <= 1'b1;
                        rd.rd_data  <= rx_sr;
                        rd.rd_match <= masked_match(rx_sr, exp_q, mask_q);
                        cnt         <= '0;
                        state       <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == CW'(IDLE_GAP - 1)) begin
                        rd.busy     <= 1'b0;
                        rd.rd_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ad9516_spi_reader.sv
// Bench for ad9516_spi_reader: AD9516 SDO device model, bus monitor and reference checks.
module tb_ad9516_spi_reader;
    localparam int CLK_DIV0 = 5, CS_SETUP0 = 2, CS_HOLD0 = 2, IDLE_GAP0 = 4;
    localparam int CLK_DIV1 = 2, CS_SETUP1 = 1, CS_HOLD1 = 1;
    // Latency from the frame definition: setup, 24 bits of two half-periods each, hold.
    localparam int LAT0 = CS_SETUP0 + 24 * 2 * CLK_DIV0 + CS_HOLD0;
    localparam int LAT1 = CS_SETUP1 + 24 * 2 * CLK_DIV1 + CS_HOLD1;

    logic sys_clk_i = 1'b0;
    logic rst_n = 1'b0;
    logic sclk0, cs0, sdio0, sclk1, cs1, sdio1;
    logic sdo0 = 1'b0, sdo1 = 1'b0;
    logic [7:0] byte0 = 8'h00, byte1 = 8'h00;

    ad9516_spi_reader_if rd0 ();
    ad9516_spi_reader_if rd1 ();

    ad9516_spi_reader u0 (
        .sys_clk_i(sys_clk_i), .rst_n(rst_n), .rd(rd0),
        .spi_sclk(sclk0), .spi_cs_n(cs0), .spi_sdio(sdio0), .spi_sdo(sdo0)
    );

    ad9516_spi_reader #(.CLK_DIV(CLK_DIV1), .CS_SETUP(CS_SETUP1), .CS_HOLD(CS_HOLD1)) u1 (
        .sys_clk_i(sys_clk_i), .rst_n(rst_n), .rd(rd1),
        .spi_sclk(sclk1), .spi_cs_n(cs1), .spi_sdio(sdio1), .spi_sdo(sdo1)
    );

    always #10 sys_clk_i = ~sys_clk_i;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    function automatic logic ref_match(input logic [7:0] d, input logic [7:0] e,
                                       input logic [7:0] m);
        logic r = 1'b1;
        for (int i = 0; i < 8; i++)
            if (m[i] && (d[i] != e[i])) r = 1'b0;
        return r;
    endfunction

    // Device models: after the 16th SCLK rise, present data MSB-first, changing on SCLK falls.
    int r0 = 0, r1 = 0;
    always @(negedge cs0) begin r0 = 0; sdo0 = 1'b0; end
    always @(posedge sclk0) r0++;
    always @(negedge sclk0) if (r0 >= 16 && r0 <= 23) sdo0 = byte0[3'(23 - r0)];
    always @(negedge cs1) begin r1 = 0; sdo1 = 1'b0; end
    always @(posedge sclk1) r1++;
    always @(negedge sclk1) if (r1 >= 16 && r1 <= 23) sdo1 = byte1[3'(23 - r1)];

    // Monitor for u0, sampled mid-cycle.
    int cyc = 0, acc_cnt = 0, acc_cyc = 0, cs_low = 0, high_run = 0, rises = 0, last_rise = 0;
    int min_per = 0, max_per = 0, ntrans = 0, nvalid = 0, v_lat = 0, v_cyc = 0;
    int t_rises = 0, t_cslow = 0, t_minp = 0, t_maxp = 0, last_gap = 0;
    logic [23:0] sdio_w = '0;
    logic [15:0] t_instr = '0;
    logic [7:0]  t_dsdio = '0, v_data = '0;
    logic        v_match = 1'b0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [15:0] instr_q[$];

    always @(negedge sys_clk_i) begin
        cyc++;
        if (rd0.rd_req === 1'b1 && rd0.rd_ready === 1'b1) begin acc_cnt++; acc_cyc = cyc; end
        if (prev_cs === 1'b1 && cs0 === 1'b0) begin
            cs_low = 0; rises = 0; sdio_w = '0; min_per = 1000; max_per = 0;
            last_gap = high_run; high_run = 0;
        end
        if (cs0 === 1'b0) cs_low++; else high_run++;
        if (cs0 === 1'b0 && sclk0 === 1'b1 && prev_sclk === 1'b0) begin
            sdio_w = {sdio_w[22:0], sdio0};
            if (rises > 0) begin
                if (cyc - last_rise < min_per) min_per = cyc - last_rise;
                if (cyc - last_rise > max_per) max_per = cyc - last_rise;
            end
            last_rise = cyc;
            rises++;
        end
        if (prev_cs === 1'b0 && cs0 === 1'b1) begin
            t_instr = sdio_w[23:8]; t_dsdio = sdio_w[7:0]; t_rises = rises;
            t_cslow = cs_low; t_minp = min_per; t_maxp = max_per;
            instr_q.push_back(sdio_w[23:8]);
            ntrans++;
        end
        if (rd0.rd_valid === 1'b1) begin
            nvalid++; v_lat = cyc - acc_cyc - 1; v_data = rd0.rd_data;
            v_match = rd0.rd_match; v_cyc = cyc;
        end
        prev_cs = cs0; prev_sclk = sclk0;
    end

    task automatic wait_ready0(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge sys_clk_i); #1;
            if (rd0.rd_ready === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_read0(input string nm, input logic [12:0] a, input logic [7:0] e,
                            input logic [7:0] m, input logic [7:0] d,
                            input logic [7:0] ed, input logic em);
        bit ok;
        int nv;
        byte0 = d; rd0.rd_addr = a; rd0.rd_exp = e; rd0.rd_mask = m;
        wait_ready0(ok);
        chk({nm, "_ready"}, 32'(ok), 1);
        nv = nvalid;
        rd0.rd_req = 1'b1;
        @(posedge sys_clk_i); #1;
        rd0.rd_req = 1'b0;
        chk({nm, "_busy"}, 32'(rd0.busy), 1);
        chk({nm, "_cs_low"}, 32'(cs0), 0);
        chk({nm, "_ready_drop"}, 32'(rd0.rd_ready), 0);
        // Disturb the inputs: the engine must work from its latched copies.
        rd0.rd_addr = 13'($urandom); rd0.rd_exp = 8'($urandom); rd0.rd_mask = 8'($urandom);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge sys_clk_i); #1;
            if (nvalid > nv) begin ok = 1'b1; break; end
        end
        chk({nm, "_valid_seen"}, 32'(ok), 1);
        chk({nm, "_latency"}, v_lat, LAT0);
        chk({nm, "_data"}, 32'(v_data), 32'(ed));
        chk({nm, "_match"}, 32'(v_match), 32'(em));
        chk({nm, "_instr"}, 32'(t_instr), 32'(16'h8000 | 16'(a)));
        chk({nm, "_sdio_data_phase"}, 32'(t_dsdio), 0);
        chk({nm, "_rises"}, t_rises, 24);
        chk({nm, "_cs_low_len"}, t_cslow, LAT0);
        chk({nm, "_sclk_per_min"}, t_minp, 2 * CLK_DIV0);
        chk({nm, "_sclk_per_max"}, t_maxp, 2 * CLK_DIV0);
    endtask

    task automatic do_read1(input string nm, input logic [7:0] d);
        bit ok;
        int lat;
        byte1 = d; rd1.rd_addr = 13'($urandom); rd1.rd_exp = 8'h00; rd1.rd_mask = 8'h00;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge sys_clk_i); #1;
            if (rd1.rd_ready === 1'b1) begin ok = 1'b1; break; end
        end
        chk({nm, "_ready"}, 32'(ok), 1);
        rd1.rd_req = 1'b1;
        @(posedge sys_clk_i); #1;
        rd1.rd_req = 1'b0;
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge sys_clk_i); #1;
            lat++;
            if (rd1.rd_valid === 1'b1) begin ok = 1'b1; break; end
        end
        chk({nm, "_valid_seen"}, 32'(ok), 1);
        chk({nm, "_latency"}, lat, LAT1);
        chk({nm, "_data"}, 32'(rd1.rd_data), 32'(d));
        chk({nm, "_match_mask0"}, 32'(rd1.rd_match), 1);
    endtask

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  exp_b;
        logic [7:0]  mask;
        logic [7:0]  sdo;
        logic [7:0]  want_data;
        logic        want_match;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int a0, nv, nt, qs, sp;
        logic [12:0] ra;
        logic [7:0] re, rm, rdd;

        vecs[0] = '{13'h01F,  8'h01, 8'h01, 8'h0E, 8'h0E, 1'b0};
        vecs[1] = '{13'h000,  8'h10, 8'hF0, 8'h18, 8'h18, 1'b1};
        vecs[2] = '{13'h000,  8'h10, 8'hFF, 8'h18, 8'h18, 1'b0};
        vecs[3] = '{13'h000,  8'h10, 8'h00, 8'h18, 8'h18, 1'b1};
        vecs[4] = '{13'h123,  8'h80, 8'hFF, 8'h80, 8'h80, 1'b1};
        vecs[5] = '{13'h123,  8'h80, 8'hFF, 8'h01, 8'h01, 1'b0};
        vecs[6] = '{13'h1FFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1};
        vecs[7] = '{13'h0AA,  8'h00, 8'hFF, 8'h00, 8'h00, 1'b1};

        rd0.rd_req = 1'b0; rd0.rd_addr = '0; rd0.rd_exp = '0; rd0.rd_mask = '0;
        rd1.rd_req = 1'b0; rd1.rd_addr = '0; rd1.rd_exp = '0; rd1.rd_mask = '0;

        // Reset state
        repeat (3) @(posedge sys_clk_i);
        #1;
        chk("rst_cs_n", 32'(cs0), 1);
        chk("rst_sclk", 32'(sclk0), 0);
        chk("rst_sdio", 32'(sdio0), 0);
        chk("rst_valid", 32'(rd0.rd_valid), 0);
        chk("rst_data", 32'(rd0.rd_data), 0);
        chk("rst_match", 32'(rd0.rd_match), 0);
        chk("rst_busy", 32'(rd0.busy), 0);
        chk("rst_ready", 32'(rd0.rd_ready), 0);
        rst_n = 1'b1;
        @(posedge sys_clk_i); #1;
        chk("ready_after_rst", 32'(rd0.rd_ready), 1);

        for (int i = 0; i < 8; i++)
            do_read0($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_b, vecs[i].mask,
                     vecs[i].sdo, vecs[i].want_data, vecs[i].want_match);

        for (int i = 0; i < 8; i++) begin
            ra = 13'($urandom); re = 8'($urandom); rm = 8'($urandom); rdd = 8'($urandom);
            if (i % 3 == 0) re = rdd ^ (8'($urandom) & ~rm);
            do_read0($sformatf("rnd%0d", i), ra, re, rm, rdd, rdd, ref_match(rdd, re, rm));
        end

        // Back-to-back with rd_req held high
        wait_ready0(ok);
        a0 = acc_cnt; nv = nvalid; nt = ntrans; qs = instr_q.size();
        byte0 = 8'h3C; rd0.rd_addr = 13'h1FFF; rd0.rd_exp = 8'h3C; rd0.rd_mask = 8'hFF;
        rd0.rd_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge sys_clk_i); #1;
            if (acc_cnt == a0 + 1) begin ok = 1'b1; break; end
        end
        chk("b2b_first_accept", 32'(ok), 1);
        rd0.rd_addr = 13'h0A5;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge sys_clk_i); #1;
            if (acc_cnt == a0 + 2) begin ok = 1'b1; break; end
        end
        sp = acc_cyc - v_cyc + 1;
        rd0.rd_req = 1'b0;
        chk("b2b_second_accept", 32'(ok), 1);
        chk("b2b_accept_spacing", sp, IDLE_GAP0 + 1);
        repeat (50) @(posedge sys_clk_i);
        #1 rd0.rd_req = 1'b1;
        repeat (5) @(posedge sys_clk_i);
        #1 rd0.rd_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge sys_clk_i); #1;
            if (nvalid == nv + 2) begin ok = 1'b1; break; end
        end
        chk("b2b_two_valids", 32'(ok), 1);
        repeat (30) @(posedge sys_clk_i);
        #1;
        chk("b2b_accepts", acc_cnt - a0, 2);
        chk("b2b_frames", ntrans - nt, 2);
        chk("b2b_instr0", 32'(instr_q[qs]), 32'h9FFF);
        chk("b2b_instr1", 32'(instr_q[qs + 1]), 32'h80A5);
        chk("b2b_cs_gap_ge4", 32'(last_gap >= 4), 1);
        chk("b2b_data", 32'(v_data), 32'h3C);

        // Reset during bit 10
        byte0 = 8'h5A; rd0.rd_addr = 13'h077; rd0.rd_exp = 8'h5A; rd0.rd_mask = 8'hFF;
        wait_ready0(ok);
        nv = nvalid;
        rd0.rd_req = 1'b1;
        @(posedge sys_clk_i); #1;
        rd0.rd_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge sys_clk_i); #1;
            if (rises == 10 && cs0 === 1'b0) begin ok = 1'b1; break; end
        end
        chk("abort_reached_bit10", 32'(ok), 1);
        rst_n = 1'b0;
        @(posedge sys_clk_i); #1;
        chk("abort_cs_n", 32'(cs0), 1);
        chk("abort_sclk", 32'(sclk0), 0);
        chk("abort_valid", 32'(rd0.rd_valid), 0);
        chk("abort_busy", 32'(rd0.busy), 0);
        chk("abort_data", 32'(rd0.rd_data), 0);
        rst_n = 1'b1;
        repeat (300) @(posedge sys_clk_i);
        #1;
        chk("abort_no_valid", nvalid - nv, 0);
        do_read0("post_abort", 13'h01F, 8'h01, 8'h01, 8'h0E, 8'h0E, 1'b0);

        // Fast-parameter instance
        do_read1("sweep_a5", 8'hA5);
        do_read1("sweep_rnd", 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
